// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for ram_fifo_ctrl.
// The slave modport is the controller; the master modport is its environment
// (upstream producer, downstream consumer and the single-port RAM).
interface ram_fifo_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
);
    // Write stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    // Read stream
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // RAM port
    logic             mem_wr;
    logic             mem_rd;
    logic [AW-1:0]    mem_add;
    logic [WIDTH-1:0] mem_data_in;
    logic [WIDTH-1:0] mem_data_out;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output mem_wr,
        output mem_rd,
        output mem_add,
        output mem_data_in,
        input  mem_data_out
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  mem_wr,
        input  mem_rd,
        input  mem_add,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port, registered-read RAM.
// One RAM access per cycle; the RAM's 1-cycle read latency is absorbed by a
// 2-entry output buffer (ob0 is the head, ob1 the entry behind it).
module ram_fifo_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    ram_fifo_ctrl_if.slave  bus,
    output logic [AW:0]     count,
    output logic            full,
    output logic            empty
);

    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

    // RAM-side bookkeeping
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      mem_count_q;
    logic             rd_pending_q;

    // Output buffer
    logic [1:0]       ob_count_q;
    logic [WIDTH-1:0] ob0_q;
    logic [WIDTH-1:0] ob1_q;

    // Decoded control
    logic             pop;
    logic [2:0]       occ;
    logic [2:0]       occ_after;
    logic             mem_has_data;
    logic             mem_has_room;
    logic             rd_ok;
    logic             wr_ok;
    logic             read_wins;
    logic             rd_fire;
    logic             wr_fire;

    // Arbitration between the write stream and buffer refill reads
    always_comb begin
        pop          = (ob_count_q != 2'd0) && bus.out_ready;
        // Entries already committed to the buffer, including a read in flight
        occ          = {1'b0, ob_count_q} + {2'b00, rd_pending_q};
        occ_after    = occ - {2'b00, pop};
        mem_has_data = (mem_count_q != '0);
        mem_has_room = (mem_count_q != DepthCnt);
        rd_ok        = mem_has_data && (occ_after < 3'd2);
        wr_ok        = bus.in_valid && mem_has_room;
        // An idle output side gets priority so the first entry drains quickly
        read_wins    = (occ == 3'd0);
        rd_fire      = !rst && rd_ok && !(wr_ok && !read_wins);
        wr_fire      = !rst && wr_ok && !rd_fire;
    end

    // Stream handshakes, RAM port drive and status flags
    always_comb begin
        bus.in_ready    = !rst && mem_has_room && !rd_fire;
        bus.mem_wr      = wr_fire;
        bus.mem_rd      = rd_fire;
        bus.mem_add     = wr_fire ? wr_ptr_q : rd_ptr_q;
        bus.mem_data_in = bus.in_data;
        bus.out_valid   = (ob_count_q != 2'd0);
        bus.out_data    = ob0_q;
        count           = mem_count_q;
        full            = (mem_count_q == DepthCnt);
        empty           = !mem_has_data && !rd_pending_q && (ob_count_q == 2'd0);
    end

    // RAM pointers, occupancy and read-in-flight flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                mem_count_q <= mem_count_q + 1'b1;
            end else if (rd_fire) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                mem_count_q <= mem_count_q - 1'b1;
            end
            rd_pending_q <= rd_fire;
        end
    end

    // Output buffer: capture returning RAM data, shift on pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ob_count_q <= 2'd0;
            ob0_q      <= '0;
            ob1_q      <= '0;
        end else begin
            unique case ({pop, rd_pending_q})
                2'b01: begin
                    // Fill only: append behind whatever is held
                    if (ob_count_q == 2'd0) begin
                        ob0_q <= bus.mem_data_out;
                    end else begin
                        ob1_q <= bus.mem_data_out;
                    end
                    ob_count_q <= ob_count_q + 2'd1;
                end
                2'b10: begin
                    // Pop only
                    ob0_q      <= ob1_q;
                    ob_count_q <= ob_count_q - 2'd1;
                end
                2'b11: begin
                    // Pop and fill together: occupancy unchanged, order kept
                    if (ob_count_q == 2'd1) begin
                        ob0_q <= bus.mem_data_out;
                    end else begin
                        ob0_q <= ob1_q;
                        ob1_q <= bus.mem_data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Structural invariants of the controller
    a_one_op: assert property (@(posedge clk) disable iff (rst) !(wr_fire && rd_fire));
    a_ob_cap: assert property (@(posedge clk) disable iff (rst) occ <= 3'd2);
    a_no_rd_empty: assert property (@(posedge clk) disable iff (rst) rd_fire |-> mem_has_data);

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller placed directly upstream of the team's single-port registered-read data RAM (d_ram).
- Accepts a valid/ready write stream and delivers a valid/ready read stream.
- Sequences the RAM's wr/rd/add/data_in ports with one RAM access per cycle, and absorbs the RAM's 1-cycle read latency in a 2-entry output buffer.

Parameters:
- DEPTH, 8: RAM entries; power of two, at least 2; must match the RAM instance.
- WIDTH, 8: data width; must match the RAM instance.
- AW, $clog2(DEPTH): RAM address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock shared with the RAM.
- rst  input  1  asynchronous active-high reset. RAM's rst_n is driven as ~rst at the parent level.
- in_valid  input  1  upstream write request.
- in_ready  output  1  controller accepts in_data this cycle.
- in_data  input  WIDTH  write data.
- out_valid  output  1  out_data holds the oldest entry.
- out_ready  input  1  downstream consumes out_data.
- out_data  output  WIDTH  head-of-FIFO data.
- mem_wr  output  1  to RAM wr.
- mem_rd  output  1  to RAM rd.
- mem_add  output  AW  to RAM add.
- mem_data_in  output  WIDTH  to RAM data_in.
- mem_data_out  input  WIDTH  from RAM data_out; valid only in the cycle after mem_rd=1, otherwise ignored (may be z).
- count  output  AW+1  entries stored in RAM and not yet read (0..DEPTH).
- full  output  1  count==DEPTH.
- empty  output  1  count==0, no read in flight, output buffer empty.

Behaviour:
- State registers: wr_ptr, rd_ptr (AW bits, natural wrap DEPTH-1 -> 0); mem_count (AW+1); rd_pending (1); ob_count (0..2) with ob0 (head) and ob1.
- Reset (async, rst=1): all state 0. out_valid=0, out_data=0, in_ready=0, mem_wr=0, mem_rd=0, mem_add=0, count=0, full=0, empty=1. Any in-flight read is discarded; RAM contents are not cleared.
- pop = out_valid && out_ready.
- Read eligibility: rd_ok = mem_count!=0 && (ob_count + rd_pending - pop) < 2.
- Write eligibility: wr_ok = in_valid && mem_count!=DEPTH.
- Single-port arbitration, at most one RAM op per cycle:
  - If ob_count+rd_pending==0, read wins over write.
  - Otherwise write wins.
  - rd_fire = rd_ok && !(wr_ok && write wins).
  - wr_fire = wr_ok && !rd_fire.
- in_ready = !rst && mem_count!=DEPTH && !rd_fire. in_ready depends combinationally on out_ready; accepted.
- mem_wr = wr_fire; mem_rd = rd_fire; mem_add = wr_fire ? wr_ptr : rd_ptr; mem_data_in = in_data. All combinational.
- On wr_fire: wr_ptr+1, mem_count+1.
- On rd_fire: rd_ptr+1, mem_count-1, rd_pending<=1. Otherwise rd_pending<=0.
- Read latency: RAM presents data in the cycle after mem_rd. When rd_pending=1, mem_data_out is written into the buffer at that cycle's edge. Appended after ob0 or ob1 by occupancy, with pop shifting ob1 into ob0 in the same edge.
- Simultaneous wr_fire and rd_fire is impossible by construction.
- Simultaneous pop and buffer fill in one cycle: occupancy stays unchanged; order preserved.
- out_valid = ob_count!=0; out_data = ob0. out_data holds its value while out_valid && !out_ready.
- Push-to-out_valid latency on an idle FIFO: 3 cycles (write at edge 0, read issued cycle 1, captured at edge 2, out_valid cycle 3).
- Max storage: DEPTH+2 entries (DEPTH in RAM plus 2 buffered).
- Full: in_ready=0, in_data ignored. Empty: mem_rd never asserted.
- Steady state with both sides active: reads and writes alternate, giving ~1 entry per 2 cycles each direction.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, mem_wr=0, mem_rd=0, out_valid=0, empty=1, count=0. After release, in_ready=1 on the first cycle.
- Single entry: push 8'h0C at cycle 0 with out_ready=1 -> mem_wr=1/add=0 in cycle 0; mem_rd=1/add=0 in cycle 1; out_valid=1, out_data=8'h0C in cycle 3; then empty=1.
- Fill: out_ready=0, offer 1..12 continuously -> exactly 10 values accepted (1..10); full=1, count=8, in_ready=0; out_data=1 held stable.
- Drain: from the filled state, out_ready=1, in_valid=0 -> out_data sequence 1..10 with no gaps in order and no duplicates; empty=1 and count=0 at the end; mem_rd never issued with mem_count=0.
- Wrap/streaming: 20 values 8'h20..8'h33 with in_valid=1 and out_ready toggling 1,1,0 -> same order out; wr_ptr/rd_ptr wrap 7->0 twice; no in_ready while full.
- Reset mid-operation: assert rst in the cycle with rd_pending=1 and ob_count=1 -> out_valid=0 immediately (async), count=0. After release, no stale data appears; the next push 8'hA5 is the first value out.
